// File: rtl/fetch_queue_if.sv
// Fetch-stage bus: instruction-memory read port, redirect request and the
// valid/ready head-of-queue interface toward decode.
interface fetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] o_imem_raddr;
    logic            o_imem_ren;
    logic [XLEN-1:0] i_imem_rdata;
    logic            i_redirect;
    logic [XLEN-1:0] i_redirect_addr;
    logic            o_valid;
    logic            i_ready;
    logic [XLEN-1:0] o_instr;
    logic [XLEN-1:0] o_pc;
    logic [XLEN-1:0] o_pc_plus4;
    logic            o_misaligned;
    logic [CW-1:0]   o_count;

    modport master (
        output o_imem_raddr, o_imem_ren, o_valid, o_instr, o_pc,
               o_pc_plus4, o_misaligned, o_count,
        input  i_imem_rdata, i_redirect, i_redirect_addr, i_ready
    );

    modport slave (
        input  o_imem_raddr, o_imem_ren, o_valid, o_instr, o_pc,
               o_pc_plus4, o_misaligned, o_count,
        output i_imem_rdata, i_redirect, i_redirect_addr, i_ready
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: PC register with sequential increment and redirect,
// feeding a DEPTH-entry queue of {pc, pc+4, instr, misaligned} toward decode.
module fetch_queue_unit #(
    parameter int              XLEN       = 32,
    parameter int              DEPTH      = 2,
    parameter logic [XLEN-1:0] RESET_ADDR = {XLEN{1'b0}}
) (
    input  logic          i_clk,
    input  logic          i_rst,
    fetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [PW-1:0]   PTR_ZERO_C = {PW{1'b0}};
    localparam logic [PW-1:0]   PTR_ONE_C  = PW'(1'b1);
    localparam logic [CW-1:0]   CNT_ZERO_C = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE_C  = CW'(1'b1);
    localparam logic [CW-1:0]   DEPTH_C    = CW'(DEPTH);
    localparam logic [XLEN-1:0] FOUR_C     = XLEN'(3'd4);

    logic [XLEN-1:0] pc_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [PW-1:0]   wr_ptr_r;
    logic [CW-1:0]   count_r;

    logic [XLEN-1:0] pc_mem_r    [DEPTH];
    logic [XLEN-1:0] pc4_mem_r   [DEPTH];
    logic [XLEN-1:0] instr_mem_r [DEPTH];
    logic            mis_mem_r   [DEPTH];

    logic            valid_s;
    logic            pop_s;
    logic            push_s;
    logic [XLEN-1:0] pc_plus4_s;
    logic [CW-1:0]   count_next_s;

    // Handshake decode: redirect blocks both push and pop; a full queue only
    // accepts a new fetch when the head leaves in the same cycle.
    always_comb begin
        valid_s    = 1'b0;
        pop_s      = 1'b0;
        push_s     = 1'b0;
        pc_plus4_s = pc_r + FOUR_C;
        if (count_r != CNT_ZERO_C) begin
            valid_s = 1'b1;
        end else begin
            valid_s = 1'b0;
        end
        if (bus.i_redirect) begin
            pop_s  = 1'b0;
            push_s = 1'b0;
        end else begin
            pop_s  = valid_s & bus.i_ready;
            push_s = (count_r < DEPTH_C) | pop_s;
        end
    end

    // Next occupancy for a non-redirect cycle: count + push - pop.
    always_comb begin
        count_next_s = count_r;
        if (push_s && !pop_s) begin
            count_next_s = count_r + CNT_ONE_C;
        end else if (pop_s && !push_s) begin
            count_next_s = count_r - CNT_ONE_C;
        end else begin
            count_next_s = count_r;
        end
    end

    // PC, pointers and occupancy; redirect restarts the queue empty at the new PC.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_r     <= RESET_ADDR;
            rd_ptr_r <= PTR_ZERO_C;
            wr_ptr_r <= PTR_ZERO_C;
            count_r  <= CNT_ZERO_C;
        end else if (bus.i_redirect) begin
            pc_r     <= bus.i_redirect_addr;
            rd_ptr_r <= PTR_ZERO_C;
            wr_ptr_r <= PTR_ZERO_C;
            count_r  <= CNT_ZERO_C;
        end else begin
            if (push_s) begin
                pc_r     <= pc_plus4_s;
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
            count_r <= count_next_s;
        end
    end

    // Entry storage; contents only matter where the pointers say they are valid.
    always_ff @(posedge i_clk) begin
        if (push_s && !i_rst) begin
            pc_mem_r[wr_ptr_r]    <= pc_r;
            pc4_mem_r[wr_ptr_r]   <= pc_plus4_s;
            instr_mem_r[wr_ptr_r] <= bus.i_imem_rdata;
            mis_mem_r[wr_ptr_r]   <= |pc_r[1:0];
        end
    end

    assign bus.o_imem_raddr = pc_r;
    assign bus.o_imem_ren   = push_s & ~i_rst;
    assign bus.o_valid      = valid_s;
    assign bus.o_count      = count_r;
    // Head fields come straight from stored entries, never from i_imem_rdata.
    assign bus.o_instr      = instr_mem_r[rd_ptr_r];
    assign bus.o_pc         = pc_mem_r[rd_ptr_r];
    assign bus.o_pc_plus4   = pc4_mem_r[rd_ptr_r];
    assign bus.o_misaligned = mis_mem_r[rd_ptr_r];
endmodule
